cmd_list_fetcher: RTL and testbench
===================================

// Module: cmd_list_fetcher
// PURPOSE
// - Producer end of the command-word stream: reads a command list (header + payload words) from on-chip
//   memory and drives cmd_valid/cmd_data into command_processor, honouring cmd_ready backpressure.
// - Sits between the host-programmed command buffer and command_processor; checks list framing in flight.
// PARAMETERS
// - ADDR_W      16  word-address width of the memory read port
// - FIFO_DEPTH  4   prefetch buffer depth in words (power of two, >=2)
// PORTS
// - clk            in   1       system clock
// - rst            in   1       synchronous active-high reset
// - start          in   1       1-cycle pulse: begin fetching; sampled only in ST_IDLE
// - base_addr      in   ADDR_W  first word address, latched on start
// - num_words      in   16      list length in words, latched on start
// - abort          in   1       stop issuing reads; discard buffered and in-flight words
// - busy           out  1       high in any state other than ST_IDLE
// - done           out  1       1-cycle pulse: list finished (normal end or abort)
// - err_trunc      out  1       sticky: list ended inside a command's payload
// - err_opcode     out  1       sticky: header opcode not in gfx_cmd_pkg table
// - mem_req        out  1       read request
// - mem_addr       out  ADDR_W  read word address
// - mem_gnt        in   1       request accepted this cycle
// - mem_rvalid     in   1       read data valid; responses return in request order
// - mem_rdata      in   32      read data
// - cmd_valid      out  1       command word valid
// - cmd_data       out  32      command word
// - cmd_ready      in   1       command_processor accepts word
// BEHAVIOUR
// - Reset: all outputs 0, state ST_IDLE, counters/FIFO cleared, err flags cleared; memory shares this reset.
// - States: ST_IDLE -> ST_FETCH (start, num_words>0) -> ST_DRAIN (all reads granted) -> ST_IDLE
//   (FIFO empty, outstanding==0, last word accepted; done pulses same cycle as entry to ST_IDLE).
// - start with num_words==0: done pulses next cycle, no reads, no cmd words; errs stay 0.
// - start also clears err_trunc/err_opcode.
// - Reads: mem_req=1 in ST_FETCH while (fifo_count + outstanding) < FIFO_DEPTH; on mem_gnt, mem_addr++
//   (wraps mod 2^ADDR_W), issued count++. outstanding++ on gnt, -- on rvalid (both same cycle: unchanged).
// - Credit rule guarantees every rvalid has a free FIFO slot; FIFO never overflows, never drops data.
// - Downstream: cmd_valid = !fifo_empty && state!=ST_ABORT; cmd_data = FIFO head (registered, stable
//   while cmd_valid && !cmd_ready). Word transfers on cmd_valid && cmd_ready; pop same cycle.
// - Min latency start->first cmd_valid: 3 cycles with 0-wait gnt and 1-cycle rvalid.
// - Framing: remaining=0 at start. On transfer: if remaining==0 word is a header:
//   remaining <= word[15:0]; opcode word[31:24] not in {CLEAR,DRAW_TRI,SET_COLOR,SET_VIEWPORT} sets
//   err_opcode (word still forwarded). Else remaining--. At list end remaining!=0 -> err_trunc.
// - Length check: headers are not used to stop fetching; exactly num_words words are sent.
// - abort (any non-idle state): go ST_ABORT; mem_req=0; flush FIFO; cmd_valid=0; swallow rvalid until
//   outstanding==0; then ST_IDLE with done pulse; errs unchanged. abort in ST_IDLE ignored.
// - abort and start same cycle in ST_IDLE: start wins. start while busy: ignored.
// - rst mid-operation: immediate return to reset state; no done pulse.
// STRUCTURE
// - gfx_cmd_pkg: opcode constants (CLEAR 8'h01, DRAW_TRI 8'h02, SET_COLOR 8'h10, SET_VIEWPORT 8'h11),
//   header field positions (OPC [31:24], RSVD [23:16], LEN [15:0]), state enum typedef.
// - Sub-module cmd_fifo (sync FIFO, FIFO_DEPTH x 32, count output); FSM + framing checker in top.
// TESTING
// - List @0x10: SET_VIEWPORT{11,00,4},0,0,4,3 ; CLEAR{01,00,0}; num_words=6, always-ready, 0-wait gnt
//   -> 6 words out in order, done once, errs 0, last mem_addr 0x15.
// - Same list, cmd_ready toggled 1-of-3 cycles, gnt random -> identical word order, cmd_data stable when
//   stalled, FIFO occupancy never exceeds 4.
// - DRAW_TRI header {02,00,6} + 3 payloads, num_words=4 -> 4 words out, done, err_trunc=1.
// - Header {7F,00,0}, num_words=1 -> word forwarded, err_opcode=1; next start clears it.
// - abort after 3 of 16 words accepted with 2 reads in flight -> cmd_valid 0 next cycle, no further
//   mem_req, done after outstanding reaches 0, busy falls with done.
// - num_words=0 start -> done 1 cycle later, no mem_req, no cmd_valid; base_addr 0xFFFF, 2 words ->
//   addresses 0xFFFF then 0x0000.

Source files
------------

// File: rtl/gfx_cmd_pkg.sv
// Shared command-list definitions: opcodes, header fields, fetcher states.
// Imported by the fetcher, its FIFO and the bus interface.
package gfx_cmd_pkg;

    typedef logic [31:0] cmd_word_t;

    localparam logic [7:0] OPC_CLEAR        = 8'h01;
    localparam logic [7:0] OPC_DRAW_TRI     = 8'h02;
    localparam logic [7:0] OPC_SET_COLOR    = 8'h10;
    localparam logic [7:0] OPC_SET_VIEWPORT = 8'h11;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 24;
    localparam int RSVD_HI = 23;
    localparam int RSVD_LO = 16;
    localparam int LEN_HI  = 15;
    localparam int LEN_LO  = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_ABORT = 2'd3;

    function automatic logic opc_known(input logic [7:0] opc);
        return (opc == OPC_CLEAR)    ||
               (opc == OPC_DRAW_TRI) ||
               (opc == OPC_SET_COLOR) ||
               (opc == OPC_SET_VIEWPORT);
    endfunction

endpackage

// File: rtl/cmd_list_fetcher_if.sv
// Memory read port plus command-word stream of the list fetcher.
// master = fetcher side, slave = memory/command_processor side.
interface cmd_list_fetcher_if
    import gfx_cmd_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    cmd_word_t         mem_rdata;
    logic              cmd_valid;
    cmd_word_t         cmd_data;
    logic              cmd_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata,
        output cmd_valid,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata,
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/cmd_list_fetcher_fifo.sv
// Prefetch buffer: synchronous FIFO with occupancy count and flush.
// Head word is read straight from the register array.
module cmd_fifo
    import gfx_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  cmd_word_t              wdata,
    input  logic                   pop,
    output cmd_word_t              rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    cmd_word_t     mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !clr) begin
            mem[wp] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rp];
    assign empty = (count == '0);

endmodule

// File: rtl/cmd_list_fetcher.sv
// Command-list fetcher: credit-limited memory reads into a prefetch
// FIFO, streamed to command_processor with header/length framing checks.
module cmd_list_fetcher
    import gfx_cmd_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [15:0]        num_words,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err_trunc,
    output logic               err_opcode,
    cmd_list_fetcher_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       num_q;
    logic [15:0]       issued;
    logic [15:0]       sent;
    logic [15:0]       remaining;
    logic [15:0]       rem_nxt;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occ;
    cmd_word_t         fifo_head;
    logic              fifo_empty;
    logic              running;
    logic              req;
    logic              gnt_take;
    logic              xfer;
    logic              is_hdr;
    logic              last;

    assign running  = (state == ST_FETCH) || (state == ST_DRAIN);
    assign occ      = {1'b0, fifo_count} + {1'b0, outstanding};
    assign req      = (state == ST_FETCH) && (occ < DEPTH_V);
    assign gnt_take = req && bus.mem_gnt;

    assign bus.mem_req   = req;
    assign bus.mem_addr  = addr_q;
    assign bus.cmd_valid = !fifo_empty && (state != ST_ABORT);
    assign bus.cmd_data  = fifo_head;

    assign xfer = bus.cmd_valid && bus.cmd_ready;
    assign last = xfer && (sent == num_q - 16'd1);
    assign busy = (state != ST_IDLE);

    always_comb begin
        is_hdr  = (remaining == 16'd0);
        rem_nxt = remaining - 16'd1;
        if (is_hdr) begin
            rem_nxt = fifo_head[LEN_HI:LEN_LO];
        end
    end

    // Responses arriving during abort are swallowed, never buffered.
    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (running && abort),
        .push  (bus.mem_rvalid && running),
        .wdata (bus.mem_rdata),
        .pop   (xfer),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            unique case ({gnt_take, bus.mem_rvalid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            num_q      <= '0;
            issued     <= '0;
            sent       <= '0;
            remaining  <= '0;
            done       <= 1'b0;
            err_trunc  <= 1'b0;
            err_opcode <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q     <= base_addr;
                        num_q      <= num_words;
                        issued     <= '0;
                        sent       <= '0;
                        remaining  <= '0;
                        err_trunc  <= 1'b0;
                        err_opcode <= 1'b0;
                        if (num_words == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH, ST_DRAIN: begin
                    if (abort) begin
                        state <= ST_ABORT;
                    end else begin
                        if (gnt_take) begin
                            addr_q <= addr_q + 1'b1;
                            issued <= issued + 16'd1;
                            if (issued == num_q - 16'd1) begin
                                state <= ST_DRAIN;
                            end
                        end
                        if (xfer) begin
                            sent      <= sent + 16'd1;
                            remaining <= rem_nxt;
                            if (is_hdr &&
                                !opc_known(fifo_head[OPC_HI:OPC_LO])) begin
                                err_opcode <= 1'b1;
                            end
                            if (last) begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                                if (rem_nxt != 16'd0) begin
                                    err_trunc <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_ABORT: begin
                    if (outstanding == '0) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_list_fetcher.sv
// Scoreboard bench for cmd_list_fetcher: behavioural memory model,
// directed command lists, and a monitor checking every accepted word.
module tb_cmd_list_fetcher;
    import gfx_cmd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] base_addr;
    logic [15:0] num_words;
    logic        busy;
    logic        done;
    logic        err_trunc;
    logic        err_opcode;

    always #5 clk = ~clk;

    cmd_list_fetcher_if #(.ADDR_W(16)) bus ();

    cmd_list_fetcher #(
        .ADDR_W     (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err_trunc  (err_trunc),
        .err_opcode (err_opcode),
        .bus        (bus)
    );

    int          total = 0;
    int          bad = 0;
    logic [31:0] mem [65536];
    logic [15:0] pending [$];
    logic [15:0] addr_log [$];
    logic [31:0] exp_q [$];
    int          done_cnt = 0;
    int          req_cnt = 0;
    int          val_cnt = 0;
    int          rv_cnt = 0;
    int          x_cnt = 0;
    int          gnt_cnt = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    bit          gnt_rand = 0;
    bit          rv_hold = 0;
    bit          rv_one = 0;
    bit          ready_man = 0;
    bit          occ_chk = 0;
    bit          stall_q = 0;
    logic [31:0] stall_d = '0;
    logic [15:0] last_addr = '0;
    int          lat;
    int          dcyc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Memory and downstream driver: inputs change on the falling edge.
    always @(negedge clk) begin
        logic [15:0] pa;
        cyc++;
        bus.mem_gnt = bus.mem_req &&
                      (!gnt_rand || ($urandom_range(0, 1) == 1));
        bus.mem_rvalid = 1'b0;
        if (pending.size() > 0 && (!rv_hold || rv_one) &&
            (!gnt_rand || $urandom_range(0, 2) != 0)) begin
            pa = pending.pop_front();
            bus.mem_rdata  = mem[pa];
            bus.mem_rvalid = 1'b1;
            rv_one = 0;
            rv_cnt++;
        end
        case (ready_mode)
            0:       bus.cmd_ready = 1'b1;
            1:       bus.cmd_ready = (cyc % 3 == 0);
            default: bus.cmd_ready = ready_man;
        endcase
        #1;
        if (bus.mem_req && bus.mem_gnt) begin
            pending.push_back(bus.mem_addr);
            addr_log.push_back(bus.mem_addr);
            last_addr = bus.mem_addr;
            gnt_cnt++;
        end
    end

    // Monitor: pops the scoreboard on every word transfer.
    always @(negedge clk) begin
        logic [31:0] e;
        #2;
        if (done) done_cnt++;
        if (bus.mem_req) req_cnt++;
        if (bus.cmd_valid) val_cnt++;
        if (stall_q && bus.cmd_valid) begin
            chk("stall_stable", bus.cmd_data, stall_d);
        end
        stall_q = bus.cmd_valid && !bus.cmd_ready;
        stall_d = bus.cmd_data;
        if (bus.cmd_valid && bus.cmd_ready) begin
            x_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_word got=%h want=none", bus.cmd_data);
            end else begin
                e = exp_q.pop_front();
                chk("word", bus.cmd_data, e);
            end
        end
        if (occ_chk) begin
            chk("occ_le_4", 32'(pending.size() + rv_cnt - x_cnt <= 4), 1);
        end
    end

    task automatic run_list(input logic [15:0] b, input logic [15:0] n,
                            input logic et, input logic eo,
                            input logic ab, input string nm,
                            output int first_lat, output int done_at);
        int cn;
        bit seen;
        done_cnt = 0;
        req_cnt = 0;
        val_cnt = 0;
        rv_cnt = 0;
        x_cnt = 0;
        gnt_cnt = 0;
        addr_log.delete();
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(mem[16'(int'(b) + i)]);
        end
        @(negedge clk);
        start = 1'b1;
        abort = ab;
        base_addr = b;
        num_words = n;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        cn = 1;
        seen = 0;
        first_lat = 0;
        done_at = 0;
        forever begin
            #3;
            if (!seen && bus.cmd_valid) begin
                first_lat = cn;
                seen = 1;
            end
            if (done) begin
                done_at = cn;
                chk({nm, "_busy_at_done"}, busy, 0);
                break;
            end
            if (cn > 3000) begin
                total++;
                bad++;
                $display("FAIL %s_timeout got=no_done want=done", nm);
                break;
            end
            @(negedge clk);
            cn++;
        end
        repeat (2) @(negedge clk);
        #3;
        chk({nm, "_done_cnt"}, done_cnt, 1);
        chk({nm, "_err_trunc"}, err_trunc, et);
        chk({nm, "_err_opcode"}, err_opcode, eo);
        chk({nm, "_missing"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

    initial begin
        int k;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h0010] = 32'h1100_0004;
        mem[16'h0011] = 32'h0000_0000;
        mem[16'h0012] = 32'h0000_0000;
        mem[16'h0013] = 32'h0000_0004;
        mem[16'h0014] = 32'h0000_0003;
        mem[16'h0015] = 32'h0100_0000;
        mem[16'h0040] = 32'h0200_0006;
        mem[16'h0041] = 32'h0000_0001;
        mem[16'h0042] = 32'h0000_0002;
        mem[16'h0043] = 32'h0000_0003;
        mem[16'h0050] = 32'h7F00_0000;
        mem[16'hFFFF] = 32'h0100_0000;
        mem[16'h0000] = 32'h01AA_0000;
        for (int i = 0; i < 16; i++) begin
            mem[16'h0100 + 16'(i)] = 32'h0100_0000 | (32'(i) << 16);
        end

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        base_addr = '0;
        num_words = '0;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        bus.cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_errs", {err_trunc, err_opcode}, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_cmd_valid", bus.cmd_valid, 0);

        run_list(16'h0010, 16'd6, 0, 0, 0, "basic", lat, dcyc);
        chk("basic_latency", lat, 3);
        chk("basic_gnts", gnt_cnt, 6);
        chk("basic_last_addr", last_addr, 16'h0015);

        gnt_rand = 1;
        ready_mode = 1;
        occ_chk = 1;
        run_list(16'h0010, 16'd6, 0, 0, 0, "stall", lat, dcyc);
        chk("stall_gnts", gnt_cnt, 6);
        gnt_rand = 0;
        ready_mode = 0;
        occ_chk = 0;

        run_list(16'h0040, 16'd4, 1, 0, 0, "trunc", lat, dcyc);
        run_list(16'h0050, 16'd1, 0, 1, 1, "badopc", lat, dcyc);

        run_list(16'h0060, 16'd0, 0, 0, 0, "zero", lat, dcyc);
        chk("zero_done_delay", dcyc, 1);
        chk("zero_no_req", req_cnt, 0);
        chk("zero_no_valid", val_cnt, 0);

        // Abort with the FIFO holding words and two reads outstanding.
        done_cnt = 0;
        x_cnt = 0;
        ready_mode = 2;
        ready_man = 1;
        for (int i = 0; i < 16; i++) exp_q.push_back(mem[16'h0100 + 16'(i)]);
        @(negedge clk);
        start = 1'b1;
        base_addr = 16'h0100;
        num_words = 16'd16;
        @(negedge clk);
        start = 1'b0;
        for (k = 0; k < 200; k++) begin
            #3;
            if (x_cnt >= 3) break;
            @(negedge clk);
        end
        ready_man = 0;
        rv_hold = 1;
        repeat (8) @(negedge clk);
        #3;
        rv_one = 1;
        repeat (4) @(negedge clk);
        #3;
        chk("abort_accepted", x_cnt, 3);
        chk("abort_inflight", pending.size(), 2);
        @(negedge clk);
        #3;
        abort = 1'b1;
        @(negedge clk);
        #3;
        abort = 1'b0;
        chk("abort_valid_low", bus.cmd_valid, 0);
        chk("abort_req_low", bus.mem_req, 0);
        chk("abort_busy", busy, 1);
        req_cnt = 0;
        rv_hold = 0;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            #3;
            if (done) break;
        end
        chk("abort_done_seen", done, 1);
        chk("abort_outst_zero", pending.size(), 0);
        chk("abort_busy_fall", busy, 0);
        repeat (2) @(negedge clk);
        #3;
        chk("abort_no_req", req_cnt, 0);
        chk("abort_done_cnt", done_cnt, 1);
        chk("abort_unsent", exp_q.size(), 13);
        chk("abort_errs", {err_trunc, err_opcode}, 0);
        exp_q.delete();
        ready_mode = 0;

        mem[16'h0000] = 32'h01BB_0000;
        run_list(16'hFFFF, 16'd2, 0, 0, 0, "wrap", lat, dcyc);
        chk("wrap_gnts", addr_log.size(), 2);
        chk("wrap_addr0", addr_log[0], 16'hFFFF);
        chk("wrap_addr1", addr_log[1], 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
